// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter.
//   arb_state_t       arbiter FSM states (IDLE / BURST)
//   MAXBURST_DEFAULT  default number of transfers per grant
//   idx_width()       bit width of a requester index for n requesters
package stream_rr_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   localparam int unsigned MAXBURST_DEFAULT = 4;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between requesters, the arbiter and the character sink.
//   req_valid / req_data / req_last / req_ready : per-requester stream, requester i
//                                                 owns req_data[i*WIDTH +: WIDTH]
//   out_data / out_valid / out_ready            : arbitrated output stream
// Modports:
//   master : environment side (requesters + sink)
//   slave  : arbiter side
interface stream_rr_arbiter_if #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned WIDTH = 8
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_data, out_valid
   );

   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_data, out_valid
   );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Finds the first set bit of req searching ptr+1, ptr+2, ... (mod NREQ).
//   req     in   NREQ  request vector
//   ptr     in   PW    index of the last winner (lowest priority)
//   onehot  out  NREQ  one-hot winner, 0 when no request
//   index   out  PW    winner index (meaningful only when any=1)
//   any     out  1     at least one request present
module rr_pick
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [PW-1:0]   index,
   output logic            any
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   int unsigned       off;
   int unsigned       pos;

   always_comb begin
      // Doubling the vector lets a plain right shift act as a rotate:
      // rot[k] is requester (ptr+1+k) mod NREQ.
      dbl = {req, req};
      rot = NREQ'(dbl >> (32'(ptr) + 32'd1));
      any = |req;

      // Scan high to low so the lowest set bit of rot is the last written.
      off = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (rot[NREQ-1-k]) off = NREQ - 1 - k;
      end

      pos = 32'(ptr) + 32'd1 + off;
      if (pos >= NREQ) pos = pos - NREQ;
      index = PW'(pos);

      onehot = '0;
      if (any) onehot[index] = 1'b1;
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter sharing one byte sink between NREQ requesters.
// A grant is held for a burst (until last, MAXBURST transfers, or the owner
// goes idle) so multi-byte sequences stay contiguous. Output is a registered
// single-entry valid/ready stage.
//   clk      in   1     rising-edge clock
//   reset    in   1     synchronous, active-high
//   bus      slave      request streams in, arbitrated stream out
//   grant    out  NREQ  one-hot current owner, 0 when idle
//   busy     out  1     burst in progress or output byte pending
//   error    out  1     sticky: owner retracted a stalled request
//   err_clr  in   1     clears error (a new violation in the same cycle wins)
module stream_rr_arbiter
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAXBURST = MAXBURST_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   stream_rr_arbiter_if.slave  bus,
   output logic [NREQ-1:0]     grant,
   output logic                busy,
   output logic                error,
   input  logic                err_clr
);

   localparam int unsigned PW = idx_width(NREQ);

   arb_state_t       state, state_nxt;
   logic [PW-1:0]    ptr, ptr_nxt;
   logic [NREQ-1:0]  grant_nxt;
   logic [3:0]       count, count_nxt;
   logic             pend, pend_nxt;
   logic             error_nxt;

   logic             can_load;
   logic             g_valid;
   logic             g_ready;
   logic             g_last;
   logic [WIDTH-1:0] g_data;
   logic             xfer;

   logic [NREQ-1:0]  pick_onehot;
   logic [PW-1:0]    pick_index;
   logic             pick_any;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req    (bus.req_valid),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .index  (pick_index),
      .any    (pick_any)
   );

   always_comb begin
      can_load      = ~bus.out_valid | bus.out_ready;
      g_ready       = (state == ARB_BURST) & can_load;
      bus.req_ready = g_ready ? grant : '0;
      // ptr always holds the index of the current owner while in BURST.
      g_valid       = bus.req_valid[ptr];
      g_last        = bus.req_last[ptr];
      g_data        = bus.req_data[ptr*WIDTH +: WIDTH];
      xfer          = g_valid & g_ready;
      busy          = (state == ARB_BURST) | bus.out_valid;

      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant;
      count_nxt = count;
      pend_nxt  = 1'b0;
      error_nxt = error;

      unique case (state)
         ARB_IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_onehot;
               ptr_nxt   = pick_index;
               count_nxt = '0;
               state_nxt = ARB_BURST;
            end
         end
         ARB_BURST: begin
            pend_nxt = g_valid & ~g_ready;
            if (xfer) begin
               count_nxt = count + 4'd1;
               if (g_last || count_nxt == 4'(MAXBURST)) begin
                  grant_nxt = '0;
                  state_nxt = ARB_IDLE;
               end
            end else if (!g_valid) begin
               grant_nxt = '0;
               state_nxt = ARB_IDLE;
            end
         end
         default: ;
      endcase

      // Retraction: owner stalled last cycle and dropped valid this cycle.
      if ((state == ARB_BURST) && pend && !g_valid) error_nxt = 1'b1;
      else if (err_clr)                             error_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ARB_IDLE;
         ptr           <= PW'(NREQ - 1);
         grant         <= '0;
         count         <= '0;
         pend          <= 1'b0;
         error         <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         grant <= grant_nxt;
         count <= count_nxt;
         pend  <= pend_nxt;
         error <= error_nxt;
         if (xfer) begin
            bus.out_data  <= g_data;
            bus.out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (NREQ=4, WIDTH=8, MAXBURST=4).
// Requester sources are per-port byte tables; expected output bytes are queued
// in arbitration order and compared as the sink accepts them.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;

   localparam int unsigned NREQ     = 4;
   localparam int unsigned WIDTH    = 8;
   localparam int unsigned MAXBURST = 4;

   logic            clk     = 1'b0;
   logic            reset   = 1'b1;
   logic            err_clr = 1'b0;
   logic [NREQ-1:0] grant;
   logic            busy;
   logic            error;

   stream_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   stream_rr_arbiter #(
      .NREQ     (NREQ),
      .WIDTH    (WIDTH),
      .MAXBURST (MAXBURST)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .grant   (grant),
      .busy    (busy),
      .error   (error),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;

   logic [7:0]      sd  [NREQ][16];
   logic            sl  [NREQ][16];
   int unsigned     pos [NREQ];
   int unsigned     len [NREQ];
   logic [7:0]      exp_q [$];
   logic [NREQ-1:0] gseen [$];
   logic [NREQ-1:0] fire;
   int              checks = 0;
   int              errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Source drive: each port presents its table entry at pos while pos < len.
   always_comb begin
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pos[i] < len[i]) begin
            bus.req_valid[i]                = 1'b1;
            bus.req_last[i]                 = sl[i][pos[i][3:0]];
            bus.req_data[i*WIDTH +: WIDTH]  = sd[i][pos[i][3:0]];
         end
      end
   end

   // Advance a source after each accepted handshake.
   initial forever begin
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (fire[i]) pos[i] = pos[i] + 1;
   end

   // Scoreboard: compare each byte the sink accepts.
   initial forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) check("sb_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
         else                   check("sb_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_src();
      for (int i = 0; i < NREQ; i++) begin
         len[i] = 0;
         pos[i] = 0;
      end
   endtask

   task automatic load(input int unsigned p, input logic [7:0] first,
                       input int unsigned n, input logic last_end);
      for (int unsigned s = 0; s < n; s++) begin
         sd[p][s] = first + 8'(s);
         sl[p][s] = last_end && (s == n - 1);
      end
      pos[p] = 0;
      len[p] = n;
   endtask

   task automatic push(input logic [7:0] b);
      exp_q.push_back(b);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_src();
      repeat (2) tick();
      clear_src();
      reset = 1'b0;
   endtask

   task automatic wait_out(input string tag, input logic [7:0] v);
      int unsigned n;
      n = 0;
      while (!(bus.out_valid === 1'b1 && bus.out_data === v) && n < 100) begin
         tick();
         n++;
      end
      check(tag, 32'(n < 100), 32'd1);
   endtask

   task automatic drain(input string tag);
      int unsigned n;
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // Log each new grant owner (grants are separated by an idle cycle).
   task automatic record_grants(input int unsigned cycles);
      logic [NREQ-1:0] prev;
      prev = '0;
      gseen.delete();
      for (int unsigned c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (grant != '0 && grant != prev) gseen.push_back(grant);
         prev = grant;
      end
   endtask

   initial begin
      bus.out_ready = 1'b1;
      clear_src();
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;

      // 1: single port, latency
      load(0, 8'h41, 2, 1'b1);
      push(8'h41); push(8'h42);
      @(negedge clk);
      check("t1_c0_grant", 32'(grant), 32'd0);
      @(negedge clk);
      check("t1_c1_grant", 32'(grant), 32'd1);
      check("t1_c1_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      check("t1_c2_valid", 32'(bus.out_valid), 32'd1);
      check("t1_c2_data", 32'(bus.out_data), 32'h41);
      @(negedge clk);
      check("t1_c3_data", 32'(bus.out_data), 32'h42);
      check("t1_c3_grant", 32'(grant), 32'd0);
      check("t1_error", 32'(error), 32'd0);
      tick();
      drain("t1");

      // 2: contention, MAXBURST rotation
      do_reset();
      load(0, 8'hA0, 6, 1'b0);
      load(1, 8'hB0, 6, 1'b0);
      for (int s = 0; s < 4; s++) push(8'hA0 + 8'(s));
      for (int s = 0; s < 4; s++) push(8'hB0 + 8'(s));
      push(8'hA4); push(8'hA5); push(8'hB4); push(8'hB5);
      record_grants(40);
      check("t2_ngrants", 32'(gseen.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check("t2_grant", k < gseen.size() ? 32'(gseen[k]) : 32'hDEAD, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      drain("t2");

      // 3: rotation fairness, 1-byte bursts
      do_reset();
      for (int unsigned p = 0; p < NREQ; p++) load(p, 8'(8'h10 * (p + 1)), 2, 1'b1);
      for (int s = 0; s < 2; s++)
         for (int p = 0; p < 4; p++) push(8'(8'h10 * (p + 1) + s));
      for (int p = 0; p < 4; p++) sl[p][0] = 1'b1;
      record_grants(40);
      check("t3_ngrants", 32'(gseen.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         check("t3_grant", k < gseen.size() ? 32'(gseen[k]) : 32'hDEAD, 32'(1 << (k % 4)));
      tick();
      drain("t3");

      // 4: backpressure mid-burst
      do_reset();
      load(0, 8'h54, 6, 1'b0);
      for (int s = 0; s < 6; s++) push(8'h54 + 8'(s));
      wait_out("t4_wait55", 8'h55);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t4_hold_data", 32'(bus.out_data), 32'h55);
         check("t4_hold_valid", 32'(bus.out_valid), 32'd1);
         check("t4_hold_ready", 32'(bus.req_ready), 32'd0);
         check("t4_hold_grant", 32'(grant), 32'd1);
      end
      tick();
      bus.out_ready = 1'b1;
      wait_out("t4_wait57", 8'h57);
      check("t4_maxburst_release", 32'(grant), 32'd0);
      drain("t4");
      check("t4_error", 32'(error), 32'd0);

      // 5: retraction error, sticky, clear
      do_reset();
      bus.out_ready = 1'b0;
      load(1, 8'h61, 2, 1'b1);
      push(8'h61);
      wait_out("t5_wait61", 8'h61);
      tick();
      len[1] = pos[1];
      @(negedge clk);
      check("t5_err_before", 32'(error), 32'd0);
      @(negedge clk);
      check("t5_err_set", 32'(error), 32'd1);
      check("t5_released", 32'(grant), 32'd0);
      tick();
      bus.out_ready = 1'b1;
      repeat (3) tick();
      check("t5_err_sticky", 32'(error), 32'd1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("t5_err_clr", 32'(error), 32'd0);
      tick();
      drain("t5");

      // 6: reset mid-burst, pointer restarts at req0
      do_reset();
      load(0, 8'h71, 4, 1'b1);
      load(1, 8'h81, 1, 1'b1);
      push(8'h71); push(8'h72);
      wait_out("t6_wait72", 8'h72);
      reset = 1'b1;
      clear_src();
      @(negedge clk);
      @(negedge clk);
      check("t6_out_valid", 32'(bus.out_valid), 32'd0);
      check("t6_grant", 32'(grant), 32'd0);
      tick();
      clear_src();
      reset = 1'b0;
      load(0, 8'h91, 1, 1'b1);
      load(1, 8'hA1, 1, 1'b1);
      push(8'h91); push(8'hA1);
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
